maxpool_l1: RTL and testbench

- Layer-1 stage of the image convolution engine, directly downstream of the convolution/layer-0 writer.
- Once the convolution stage has filled layer-0 memory (64x64 signed 20-bit results), this block reads it through the shared memory port.
- Performs 2x2 max pooling, stride 2, and writes the 32x32 result to layer-1 memory.

---
 rtl/maxpool_l1.sv | 176 +++++++++++++++++
 tb/tb_maxpool_l1.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_l1.sv
// Layer-1 2x2/stride-2 max pooling: reads layer-0 memory, writes the pooled image to layer-1 memory.
// Optional build macro MAXPOOL_RELU_EN clamps negative pooled values to zero before the write.
module maxpool_l1 #(
   parameter int         IMG_W   = 64,
   parameter int         DW      = 20,
   parameter int         AW      = 12,
   parameter logic [2:0] SRC_SEL = 3'b001,
   parameter logic [2:0] DST_SEL = 3'b011
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          cwr,
   output logic [AW-1:0] caddr_wr,
   output logic [DW-1:0] cdata_wr,
   output logic [2:0]    csel
);

   localparam int HALF = IMG_W / 2;
   localparam int LW   = $clog2(IMG_W);
   localparam int CW   = $clog2(HALF);
   localparam logic [CW-1:0] IDX_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] IDX_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LAST,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] r_reg, r_next;
   logic [CW-1:0] c_reg, c_next;
   logic [1:0]    k_reg, k_next;
   logic [DW-1:0] max_reg, max_next;

   logic          busy_next, done_next, crd_next, cwr_next;
   logic [AW-1:0] caddr_rd_next, caddr_wr_next;
   logic [DW-1:0] cdata_wr_next;
   logic [2:0]    csel_next;
   logic          sample, first;

   // k selects (dy,dx) = (k[1],k[0]), giving the row-major order 00,01,10,11
   function automatic logic [AW-1:0] rd_addr(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                             input logic [1:0] k);
      logic [AW-1:0] row;
      logic [AW-1:0] col;
      row = AW'({r, k[1]});
      col = AW'({c, k[0]});
      return (row << LW) + col;
   endfunction

   function automatic logic [AW-1:0] wr_addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return (AW'(r) << CW) + AW'(c);
   endfunction

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      c_next     = c_reg;
      k_next     = k_reg;
      max_next   = max_reg;

      // read data lags the request by two edges: samples land at the ends of READ k=1..3 and LAST
      sample = ((state_reg == S_READ) && (k_reg != 2'd0)) || (state_reg == S_LAST);
      first  = (state_reg == S_READ) && (k_reg == 2'd1);
      if (sample && (first || ($signed(cdata_rd) > $signed(max_reg)))) begin
         max_next = cdata_rd;
      end

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_READ;
               r_next     = '0;
               c_next     = '0;
               k_next     = 2'd0;
            end
         end
         S_READ: begin
            if (k_reg == 2'd3) begin
               state_next = S_LAST;
            end else begin
               k_next = k_reg + 2'd1;
            end
         end
         S_LAST: begin
            state_next = S_WRITE;
         end
         S_WRITE: begin
            k_next     = 2'd0;
            state_next = S_READ;
            if (c_reg == IDX_LAST) begin
               c_next = '0;
               if (r_reg == IDX_LAST) begin
                  r_next     = '0;
                  state_next = S_DONE;
               end else begin
                  r_next = r_reg + IDX_ONE;
               end
            end else begin
               c_next = c_reg + IDX_ONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // outputs are registered, so they are derived from the state being entered
      crd_next      = (state_next == S_READ);
      cwr_next      = (state_next == S_WRITE);
      busy_next     = (state_next == S_READ) || (state_next == S_LAST) || (state_next == S_WRITE);
      done_next     = (state_next == S_DONE);
      caddr_rd_next = crd_next ? rd_addr(r_next, c_next, k_next) : caddr_rd;
      caddr_wr_next = cwr_next ? wr_addr(r_reg, c_reg) : caddr_wr;
      cdata_wr_next = cwr_next ? relu(max_next) : cdata_wr;

      case (state_next)
         S_READ, S_LAST: csel_next = SRC_SEL;
         S_WRITE:        csel_next = DST_SEL;
         default:        csel_next = 3'b000;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         r_reg     <= '0;
         c_reg     <= '0;
         k_reg     <= 2'd0;
         max_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         crd       <= 1'b0;
         cwr       <= 1'b0;
         caddr_rd  <= '0;
         caddr_wr  <= '0;
         cdata_wr  <= '0;
         csel      <= 3'b000;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         c_reg     <= c_next;
         k_reg     <= k_next;
         max_reg   <= max_next;
         busy      <= busy_next;
         done      <= done_next;
         crd       <= crd_next;
         cwr       <= cwr_next;
         caddr_rd  <= caddr_rd_next;
         caddr_wr  <= caddr_wr_next;
         cdata_wr  <= cdata_wr_next;
         csel      <= csel_next;
      end
   end

endmodule

// File: tb/tb_maxpool_l1.sv
// Bench for maxpool_l1: memory model, scoreboard of expected layer-1 writes, protocol monitor.
module tb_maxpool_l1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, crd, cwr;
   logic [11:0] caddr_rd, caddr_wr;
   logic [19:0] cdata_rd = '0;
   logic [19:0] cdata_wr;
   logic [2:0]  csel;

   logic [19:0] l0 [0:4095];
   logic [19:0] l1 [0:1023];

   int n_checks = 0;
   int n_pass   = 0;
   int write_cnt = 0;
   int done_cnt  = 0;
   int rd_idx    = 0;
   logic [11:0] rd_log [0:3];
   int exp_addr [$];
   int exp_data [$];

   maxpool_l1 dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .csel     (csel)
   );

   always #5 clk = ~clk;

   // layer-0 memory: one-cycle registered read
   always @(posedge clk) begin
      if (crd && csel == 3'b001) cdata_rd <= l0[caddr_rd];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [19:0] win_max(input int r, input int c);
      logic signed [19:0] m;
      logic signed [19:0] v [4];
      v[0] = l0[(2*r)*64 + 2*c];
      v[1] = l0[(2*r)*64 + 2*c + 1];
      v[2] = l0[(2*r+1)*64 + 2*c];
      v[3] = l0[(2*r+1)*64 + 2*c + 1];
      m = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = '0;
`endif
      return m;
   endfunction

   task automatic push_expected();
      exp_addr.delete();
      exp_data.delete();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++) begin
            exp_addr.push_back(r*32 + c);
            exp_data.push_back(int'(win_max(r, c)));
         end
   endtask

   // protocol monitor and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (crd || cwr) check("rd_wr_exclusive", {31'd0, crd & cwr}, 32'd0);
         if (crd) begin
            check("csel_on_read", csel, 3'b001);
            if (rd_idx >= 4 && rd_idx < 8) rd_log[rd_idx-4] = caddr_rd;
            rd_idx++;
         end
         if (cwr) begin
            check("csel_on_write", csel, 3'b011);
            l1[caddr_wr[9:0]] = cdata_wr;
            write_cnt++;
            if (exp_addr.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               check("wr_addr", caddr_wr, exp_addr.pop_front());
               check("wr_data", cdata_wr, exp_data.pop_front());
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic run_frame(input bit extra_start);
      int cyc;
      push_expected();
      write_cnt = 0;
      done_cnt  = 0;
      rd_idx    = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check("busy_after_start", busy, 1'b1);
      check("first_rd_addr", caddr_rd, 12'd0);
      while (!done && cyc < 6200) begin
         start = (extra_start && (cyc == 10 || cyc == 3000)) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
      check("done_cycle", cyc, 6145);
      check("busy_at_done", busy, 1'b0);
      if (extra_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         check("start_at_done_ignored", busy, 1'b0);
      end
      repeat (20) @(posedge clk);
      #1;
      check("idle_no_read", crd, 1'b0);
      check("idle_csel", csel, 3'b000);
      check("write_count", write_cnt, 1024);
      check("done_count", done_cnt, 1);
      check("scoreboard_empty", exp_addr.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_crd"}, crd, 1'b0);
      check({tag, "_cwr"}, cwr, 1'b0);
      check({tag, "_caddr_rd"}, caddr_rd, 12'd0);
      check({tag, "_caddr_wr"}, caddr_wr, 12'd0);
      check({tag, "_cdata_wr"}, cdata_wr, 20'd0);
      check({tag, "_csel"}, csel, 3'd0);
   endtask

   initial begin
      int guard;
      logic [19:0] neg_exp;
      reset = 1'b1;
      start = 1'b0;
      for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_hold", crd, 1'b0);

      // ramp image with stray starts mid-frame and at done
      run_frame(1'b1);
      check("rd_seq_0", rd_log[0], 12'd2);
      check("rd_seq_1", rd_log[1], 12'd3);
      check("rd_seq_2", rd_log[2], 12'd66);
      check("rd_seq_3", rd_log[3], 12'd67);
      check("ramp_l1_first", l1[0], 20'd65);
      check("ramp_l1_last", l1[1023], 20'd4095);

      // random image with an all-negative window 0
      for (int a = 0; a < 4096; a++) l0[a] = 20'($urandom);
      l0[0] = 20'hFFFFB; l0[1] = 20'hFFFFD; l0[64] = 20'hFFFF7; l0[65] = 20'hFFFFD;
`ifdef MAXPOOL_RELU_EN
      neg_exp = 20'h00000;
`else
      neg_exp = 20'hFFFFD;
`endif
      run_frame(1'b0);
      check("neg_window", l1[0], neg_exp);

      // mixed signs: signed compare must pick the largest positive value
      l0[0] = 20'h80000; l0[1] = 20'h7FFFF; l0[64] = 20'h00000; l0[65] = 20'hFFFFF;
      run_frame(1'b0);
      check("mixed_window", l1[0], 20'h7FFFF);

      // reset during window 100, READ k=2
      for (int a = 0; a < 4096; a++) l0[a] = 20'(a);
      push_expected();
      write_cnt = 0;
      rd_idx = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (!(crd && rd_idx == 402) && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 3000) check("win100_timeout", 32'd0, 32'd1);
      check("win100_k2_addr", caddr_rd, 12'd456);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midrst");
      exp_addr.delete();
      exp_data.delete();
      write_cnt = 0;
      reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("no_write_after_rst", write_cnt, 0);
      check("idle_after_rst", busy, 1'b0);

      l1[0] = 20'h0;
      run_frame(1'b0);
      check("fresh_l1_first", l1[0], 20'd65);
      check("fresh_l1_last", l1[1023], 20'd4095);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
